// File: rtl/div_wb_scheduler_pkg.sv
// div_wb_scheduler_pkg
//   Shared constants and types for the divider writeback scheduler.
//   A divider tag is 7 bits: {valid, get_rem, rd[4:0]}. The bit offsets are
//   exported so the flattened div_busy bus can be decoded by consumers.
package div_wb_scheduler_pkg;

   localparam int DIV_LAT_DEF = 8;
   localparam int XLEN_DEF    = 32;
   localparam int TAG_W       = 7;
   localparam int TAG_VALID   = 6;
   localparam int TAG_REM     = 5;
   localparam int TAG_RD_HI   = 4;
   localparam int TAG_RD_LO   = 0;

   // Field order matches the bit offsets above (valid is the MSB).
   typedef struct packed {
      logic       valid;
      logic       get_rem;
      logic [4:0] rd;
   } div_tag_t;

   // A write to x0 never creates a dependence.
   function automatic logic rd_hit(input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
      return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/div_wb_scheduler_div_tag_pipe.sv
// div_tag_pipe
//   DIV_LAT-deep shift register of divider tags that runs in lockstep with the
//   divider datapath. Never stalls, never flushes.
//   Ports:
//     clk_i/rst_i          clock, synchronous active-high reset
//     issue_i/get_rem_i/rd_i  divide entering the divider this cycle
//     rs1_i/rs2_i          decode sources for the RAW query
//     busy_o               all slots, slot k at [7k+6:7k]
//     raw_hit_o            some valid slot with nonzero rd matches a source
//     tail_o               slot DIV_LAT-1 (completing this cycle)
//     near_wb_o            slot DIV_LAT-3 valid (reaches W together with decode)
module div_tag_pipe
   import div_wb_scheduler_pkg::*;
#(
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       issue_i,
   input  logic                       get_rem_i,
   input  logic [4:0]                 rd_i,
   input  logic [4:0]                 rs1_i,
   input  logic [4:0]                 rs2_i,
   output logic [TAG_W*DIV_LAT-1:0]   busy_o,
   output logic                       raw_hit_o,
   output div_tag_t                   tail_o,
   output logic                       near_wb_o
);

   div_tag_t [DIV_LAT-1:0] slots_q, slots_d;
   div_tag_t               new_tag;

   always_comb begin
      new_tag = '0;
      if (issue_i) begin
         new_tag.valid   = 1'b1;
         new_tag.get_rem = get_rem_i;
         new_tag.rd      = rd_i;
      end
      slots_d = {slots_q[DIV_LAT-2:0], new_tag};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) slots_q <= '0;
      else       slots_q <= slots_d;
   end

   always_comb begin
      raw_hit_o = 1'b0;
      for (int k = 0; k < DIV_LAT; k++)
         if (slots_q[k].valid && rd_hit(slots_q[k].rd, rs1_i, rs2_i)) raw_hit_o = 1'b1;
   end

   assign busy_o    = slots_q;
   assign tail_o    = slots_q[DIV_LAT-1];
   // Decode at c reaches W at c+3; slot DIV_LAT-3 at c also writes at c+3.
   assign near_wb_o = slots_q[DIV_LAT-3].valid;

endmodule

// File: rtl/div_wb_scheduler.sv
// div_wb_scheduler
//   Tracks in-flight divides, raises decode stalls (divider RAW and predicted
//   writeback collisions) and owns the single register-file write port.
//   Writeback priority: divider completion > skid entry > memory stage.
//   Ports:
//     clk/rst               clock, synchronous active-high reset
//     d_*                   decode-stage instruction info
//     x_div_*               divide issuing into the divider
//     div_quotient/remainder divider outputs for the slot DIV_LAT-1 tag
//     m_*                   memory-stage writeback request
//     stall_*               combinational decode stalls
//     w_*                   registered register-file write port
//     div_busy              flattened tag pipeline
//     wb_overflow           sticky: an M result was dropped
//     stall_cycles          wrapping count of stalled cycles
module div_wb_scheduler
   import div_wb_scheduler_pkg::*;
#(
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int XLEN    = XLEN_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               d_rs1,
   input  logic [4:0]               d_rs2,
   input  logic                     d_reg_we,
   input  logic                     d_is_div,
   input  logic                     x_div_issue,
   input  logic [4:0]               x_div_rd,
   input  logic                     x_div_get_rem,
   input  logic [XLEN-1:0]          div_quotient,
   input  logic [XLEN-1:0]          div_remainder,
   input  logic                     m_reg_we,
   input  logic [4:0]               m_rd,
   input  logic [XLEN-1:0]          m_data,
   output logic                     stall_div_raw,
   output logic                     stall_wb_collision,
   output logic                     w_reg_we,
   output logic [4:0]               w_rd,
   output logic [XLEN-1:0]          w_data,
   output logic [TAG_W*DIV_LAT-1:0] div_busy,
   output logic                     wb_overflow,
   output logic [31:0]              stall_cycles
);

   div_tag_t        tail;
   logic            tag_raw, near_wb;

   logic            skid_v_q, skid_v_d;
   logic [4:0]      skid_rd_q, skid_rd_d;
   logic [XLEN-1:0] skid_data_q, skid_data_d;
   logic            w_we_q, w_we_d;
   logic [4:0]      w_rd_q, w_rd_d;
   logic [XLEN-1:0] w_data_q, w_data_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     stall_cnt_q, stall_cnt_d;

   div_tag_pipe #(.DIV_LAT(DIV_LAT)) u_tags (
      .clk_i     (clk),
      .rst_i     (rst),
      .issue_i   (x_div_issue),
      .get_rem_i (x_div_get_rem),
      .rd_i      (x_div_rd),
      .rs1_i     (d_rs1),
      .rs2_i     (d_rs2),
      .busy_o    (div_busy),
      .raw_hit_o (tag_raw),
      .tail_o    (tail),
      .near_wb_o (near_wb)
   );

   // The issuing divide is not in slot 0 yet, so it is matched directly.
   assign stall_div_raw = tag_raw
                        | (x_div_issue & rd_hit(x_div_rd, d_rs1, d_rs2))
                        | (skid_v_q & rd_hit(skid_rd_q, d_rs1, d_rs2));
   assign stall_wb_collision = near_wb & d_reg_we & ~d_is_div;

   always_comb begin
      w_we_d      = 1'b0;
      w_rd_d      = '0;
      w_data_d    = '0;
      skid_v_d    = skid_v_q;
      skid_rd_d   = skid_rd_q;
      skid_data_d = skid_data_q;
      ovf_d       = ovf_q;
      if (tail.valid) begin
         w_we_d   = 1'b1;
         w_rd_d   = tail.rd;
         w_data_d = tail.get_rem ? div_remainder : div_quotient;
         if (m_reg_we) begin
            if (!skid_v_q) begin
               skid_v_d    = 1'b1;
               skid_rd_d   = m_rd;
               skid_data_d = m_data;
            end else begin
               // No room left: the older skid entry is kept, M is lost.
               ovf_d = 1'b1;
            end
         end
      end else if (skid_v_q) begin
         w_we_d   = 1'b1;
         w_rd_d   = skid_rd_q;
         w_data_d = skid_data_q;
         // Drain and reload in the same cycle when M also wants the port.
         skid_v_d    = m_reg_we;
         skid_rd_d   = m_rd;
         skid_data_d = m_data;
      end else if (m_reg_we) begin
         w_we_d   = 1'b1;
         w_rd_d   = m_rd;
         w_data_d = m_data;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_div_raw | stall_wb_collision) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_v_q    <= 1'b0;
         skid_rd_q   <= '0;
         skid_data_q <= '0;
         w_we_q      <= 1'b0;
         w_rd_q      <= '0;
         w_data_q    <= '0;
         ovf_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         skid_v_q    <= skid_v_d;
         skid_rd_q   <= skid_rd_d;
         skid_data_q <= skid_data_d;
         w_we_q      <= w_we_d;
         w_rd_q      <= w_rd_d;
         w_data_q    <= w_data_d;
         ovf_q       <= ovf_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign w_reg_we     = w_we_q;
   assign w_rd         = w_rd_q;
   assign w_data       = w_data_q;
   assign wb_overflow  = ovf_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_div_wb_scheduler.sv
// Directed bench for div_wb_scheduler. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Every write the DUT
// should perform is queued when its stimulus is driven and popped by the
// writeback monitor in issue/arrival order.
module tb_div_wb_scheduler;

   logic        clk, rst;
   logic [4:0]  d_rs1, d_rs2;
   logic        d_reg_we, d_is_div;
   logic        x_div_issue, x_div_get_rem;
   logic [4:0]  x_div_rd;
   logic [31:0] div_quotient, div_remainder;
   logic        m_reg_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        stall_div_raw, stall_wb_collision;
   logic        w_reg_we;
   logic [4:0]  w_rd;
   logic [31:0] w_data;
   logic [55:0] div_busy;
   logic        wb_overflow;
   logic [31:0] stall_cycles;

   div_wb_scheduler #(.DIV_LAT(8), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .d_reg_we(d_reg_we), .d_is_div(d_is_div),
      .x_div_issue(x_div_issue), .x_div_rd(x_div_rd), .x_div_get_rem(x_div_get_rem),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .m_reg_we(m_reg_we), .m_rd(m_rd), .m_data(m_data),
      .stall_div_raw(stall_div_raw), .stall_wb_collision(stall_wb_collision),
      .w_reg_we(w_reg_we), .w_rd(w_rd), .w_data(w_data),
      .div_busy(div_busy), .wb_overflow(wb_overflow), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          g;
   logic [31:0] sc0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Writeback monitor / scoreboard.
   always @(negedge clk) begin : mon
      wr_t e;
      if (w_reg_we === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_wr", 64'(w_reg_we), 64'd0);
         else begin
            e = sb.pop_front();
            chk("wr_rd", 64'(w_rd), 64'(e.rd));
            chk("wr_data", 64'(w_data), 64'(e.data));
         end
      end
   end

   // Divider output model: during global cycle n the datapath shows
   // quotient 0x1000+n and remainder 0x2000+n.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      div_quotient  = 32'h1000 + 32'(cyc);
      div_remainder = 32'h2000 + 32'(cyc);
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear();
      d_rs1 = 0; d_rs2 = 0; d_reg_we = 0; d_is_div = 0;
      x_div_issue = 0; x_div_rd = 0; x_div_get_rem = 0;
      m_reg_we = 0; m_rd = 0; m_data = 0;
   endtask

   // Issue during the current cycle; result is sampled DIV_LAT cycles later.
   task automatic issue(input logic [4:0] rd, input logic rem);
      wr_t e;
      x_div_issue = 1; x_div_rd = rd; x_div_get_rem = rem;
      e.rd   = rd;
      e.data = rem ? 32'h2000 + 32'(cyc + 8) : 32'h1000 + 32'(cyc + 8);
      sb.push_back(e);
   endtask

   task automatic push_m(input logic [4:0] rd, input logic [31:0] data);
      wr_t e;
      m_reg_we = 1; m_rd = rd; m_data = data;
      e.rd = rd; e.data = data;
      sb.push_back(e);
   endtask

   initial begin
      clear();
      rst = 1;
      div_quotient = 0; div_remainder = 0;
      step(); step();
      mid();
      chk("rst_we", 64'(w_reg_we), 0);
      chk("rst_rd", 64'(w_rd), 0);
      chk("rst_data", 64'(w_data), 0);
      chk("rst_busy", 64'(div_busy), 0);
      chk("rst_ovf", 64'(wb_overflow), 0);
      chk("rst_cnt", 64'(stall_cycles), 0);
      step();
      rst = 0;

      // Single divide: slot walk, write at t+9, nothing else.
      sc0 = stall_cycles;
      issue(5, 0);
      mid();
      chk("single_busy_t0", 64'(div_busy), 0);
      step(); x_div_issue = 0;
      for (int k = 0; k < 8; k++) begin
         logic [55:0] eb;
         eb = 56'h45 << (7 * k);
         mid();
         chk($sformatf("single_busy_slot%0d", k), 64'(div_busy), 64'(eb));
         step();
      end
      mid(); chk("single_we_t9", 64'(w_reg_we), 1);
      step();
      mid(); chk("single_idle_t10", 64'(w_reg_we), 0);
      chk("single_no_stall", 64'(stall_cycles), 64'(sc0));
      step();

      // RAW: rs1 matches a pending divide from issue through slot 7.
      clear(); d_rs1 = 6;
      sc0 = stall_cycles;
      issue(6, 0);
      for (int t = 0; t < 10; t++) begin
         mid();
         chk($sformatf("raw_t%0d", t), 64'(stall_div_raw), 64'(t <= 8));
         step(); x_div_issue = 0;
      end
      mid(); chk("raw_cnt", 64'(stall_cycles), 64'(sc0 + 9));
      step();

      // No RAW: x0 destination, and an unrelated source.
      clear(); d_rs1 = 7; d_rs2 = 0;
      issue(0, 1);
      for (int t = 0; t < 11; t++) begin
         mid();
         chk($sformatf("noraw_t%0d", t), 64'(stall_div_raw), 0);
         step();
         if (t == 0) issue(6, 0); else x_div_issue = 0;
      end

      // Collision stall only when slot 5 is valid and decode is a non-div writer.
      clear(); d_reg_we = 1;
      issue(3, 0);
      for (int t = 0; t < 10; t++) begin
         mid();
         chk($sformatf("coll_t%0d", t), 64'(stall_wb_collision), 64'(t == 6));
         step(); x_div_issue = 0;
      end
      d_is_div = 1;
      issue(3, 1);
      for (int t = 0; t < 10; t++) begin
         mid();
         chk($sformatf("coll_div_t%0d", t), 64'(stall_wb_collision), 0);
         step(); x_div_issue = 0;
      end

      // Plain M result: written the following cycle.
      clear();
      push_m(11, 32'hCC);
      step(); m_reg_we = 0;
      mid(); chk("m_direct_rd", 64'(w_rd), 11);
      step();

      // Skid: M loses to the divider, then drains while reloading.
      clear();
      issue(4, 1);
      for (int t = 0; t < 8; t++) begin step(); x_div_issue = 0; end
      push_m(9, 32'hAA);
      step();
      push_m(10, 32'hBB);
      mid(); chk("skid_t9_rd", 64'(w_rd), 4);
      step(); m_reg_we = 0;
      mid(); chk("skid_t10_rd", 64'(w_rd), 9);
      chk("skid_t10_data", 64'(w_data), 64'h0AA);
      step();
      mid(); chk("skid_t11_rd", 64'(w_rd), 10);
      chk("skid_ovf", 64'(wb_overflow), 0);
      step();

      // Overflow: two consecutive completions each meet an M result.
      clear();
      issue(12, 0);
      step();
      issue(13, 0);
      step(); x_div_issue = 0;
      for (int t = 2; t < 8; t++) step();
      push_m(14, 32'hDD);
      mid(); chk("ovf_t8", 64'(wb_overflow), 0);
      step();
      m_rd = 15; m_data = 32'hEE;  // dropped, so not queued
      step(); m_reg_we = 0;
      mid(); chk("ovf_t10", 64'(wb_overflow), 1);
      chk("ovf_t10_rd", 64'(w_rd), 13);
      step();
      mid(); chk("ovf_t11_rd", 64'(w_rd), 14);
      chk("ovf_t11_data", 64'(w_data), 64'hDD);
      for (int t = 0; t < 4; t++) step();
      mid(); chk("ovf_sticky", 64'(wb_overflow), 1);
      step();

      // Reset mid-flight: divide discarded, everything cleared.
      clear(); d_rs1 = 7;
      x_div_issue = 1; x_div_rd = 7;
      step(); x_div_issue = 0;
      step(); step();
      rst = 1;
      mid();
      step();
      rst = 0;
      mid();
      chk("rstmf_we", 64'(w_reg_we), 0);
      chk("rstmf_busy", 64'(div_busy), 0);
      chk("rstmf_ovf", 64'(wb_overflow), 0);
      chk("rstmf_cnt", 64'(stall_cycles), 0);
      chk("rstmf_raw", 64'(stall_div_raw), 0);
      for (int t = 4; t < 11; t++) step();
      mid(); chk("rstmf_t10_busy", 64'(div_busy), 0);
      step();

      // Same rd issued as the older divide completes: both tracked, in order.
      clear(); d_rs1 = 8;
      issue(8, 0);
      for (int t = 0; t < 8; t++) begin step(); x_div_issue = 0; end
      issue(8, 1);
      mid(); chk("same_t8_raw", 64'(stall_div_raw), 1);
      chk("same_t8_slot7", 64'(div_busy[55]), 1);
      step(); x_div_issue = 0;
      mid(); chk("same_t9_raw", 64'(stall_div_raw), 1);
      chk("same_t9_rd", 64'(w_rd), 8);
      for (int t = 9; t < 19; t++) step();
      d_rs1 = 0;
      mid(); chk("same_drained_raw", 64'(stall_div_raw), 0);

      clear();
      step(); step(); step();
      mid();
      chk("sb_empty", 64'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
